// File: rtl/sqrt_seq_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_seq_pkg
// Shared types for the integer square-root sequencer: the FSM state encoding,
// the AU1 opcode constants and the packed control bundle that the decoder
// hands back to the top level.
// -----------------------------------------------------------------------------
package sqrt_seq_pkg;

  // Seven sequencer states in a 3-bit encoding; IDLE must stay at zero so a
  // cleared state register decodes to the all-quiet control word.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SUB   = 3'd3,
    ST_TEST  = 3'd4,
    ST_WB    = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // AU1 opcodes as the datapath expects them.
  localparam logic [1:0] AU_PASS = 2'b00;
  localparam logic [1:0] AU_ADD  = 2'b01;
  localparam logic [1:0] AU_SUB  = 2'b10;
  localparam logic [1:0] AU_SHL  = 2'b11;

  // Every strobe the datapath needs, plus the handshake flags, in one word.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rad_ld;
    logic       rem_clr;
    logic       root_clr;
    logic       sh_en;
    logic [1:0] au_op;
    logic       au_tri;
    logic       in_tri;
    logic       rem_ld;
    logic       root_lsb_set;
    logic       rf_oe;
    logic       rf_ws;
    logic       rf_rs;
  } ctrl_t;

endpackage

// File: rtl/sqrt_seq_decode.sv
// -----------------------------------------------------------------------------
// sqrt_seq_decode
// Moore-style decode of the sequencer state into the datapath control bundle.
// The only input other than the state is the AU sign flag, which qualifies the
// remainder/root update during TEST.
//
// Ports:
//   state  in   current sequencer state
//   au_neg in   sign of the AU1 trial subtraction
//   ctrl   out  control bundle (strobes, AU opcode, handshake flags)
// -----------------------------------------------------------------------------
module sqrt_seq_decode
  import sqrt_seq_pkg::*;
(
  input  state_t state,
  input  logic   au_neg,
  output ctrl_t  ctrl
);

  // Start from the all-quiet word (which is also the IDLE decode) and raise
  // only the strobes that belong to the current state.
  always_comb begin
    ctrl       = '0;
    ctrl.au_op = AU_PASS;
    unique case (state)
      ST_IDLE: ;
      ST_LOAD: begin
        ctrl.busy     = 1'b1;
        ctrl.rad_ld   = 1'b1;
        ctrl.rem_clr  = 1'b1;
        ctrl.root_clr = 1'b1;
        ctrl.in_tri   = 1'b1;
      end
      ST_SHIFT: begin
        ctrl.busy  = 1'b1;
        ctrl.sh_en = 1'b1;
        ctrl.au_op = AU_SHL;
      end
      ST_SUB: begin
        ctrl.busy   = 1'b1;
        ctrl.au_op  = AU_SUB;
        ctrl.au_tri = 1'b1;
      end
      ST_TEST: begin
        // A non-negative trial result means the trial bit belongs in the root
        // and the difference becomes the new remainder.
        ctrl.busy         = 1'b1;
        ctrl.au_tri       = 1'b1;
        ctrl.rem_ld       = ~au_neg;
        ctrl.root_lsb_set = ~au_neg;
      end
      ST_WB: begin
        ctrl.busy  = 1'b1;
        ctrl.rf_oe = 1'b1;
        ctrl.rf_ws = 1'b1;
      end
      ST_DONE: begin
        ctrl.busy = 1'b1;
        ctrl.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_seq_ctrl
// Self-sequencing controller for the structural integer square-root datapath.
// Runs LOAD, then ITERS rounds of SHIFT/SUB/TEST, then WB and DONE, and
// decodes the state into datapath strobes through sqrt_seq_decode.
//
// Optional feature: define SQRT_SEQ_ABORT_EN to add the abort input, which
// returns a busy sequencer to IDLE at the next edge without a done pulse.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request, sampled only in IDLE
//   au_neg               AU1 sign flag, used in TEST
//   abort                cancel request (SQRT_SEQ_ABORT_EN only)
//   busy, done           handshake (busy outside IDLE, done one cycle)
//   iter                 current root-bit iteration, 0..ITERS-1
//   rad_ld .. rf_rs      datapath strobes and AU1 opcode
// -----------------------------------------------------------------------------
module sqrt_seq_ctrl
  import sqrt_seq_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int ITERS  = DATA_W / 2,
  localparam int CNT_W  = $clog2(ITERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             au_neg,
`ifdef SQRT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter,
  output logic             rad_ld,
  output logic             rem_clr,
  output logic             root_clr,
  output logic             sh_en,
  output logic [1:0]       au_op,
  output logic             au_tri,
  output logic             in_tri,
  output logic             rem_ld,
  output logic             root_lsb_set,
  output logic             rf_oe,
  output logic             rf_ws,
  output logic             rf_rs
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERS - 1);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   last_iter;
  logic   cancel;

  assign last_iter = (iter == ITER_LAST);

`ifdef SQRT_SEQ_ABORT_EN
  assign cancel = abort;
`else
  assign cancel = 1'b0;
`endif

  // Next-state logic. A cancel overrides everything, including a start that
  // arrives in IDLE, so an aborting requester never launches a new run.
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_SHIFT;
        ST_SHIFT: state_nxt = ST_SUB;
        ST_SUB:   state_nxt = ST_TEST;
        ST_TEST:  state_nxt = last_iter ? ST_WB : ST_SHIFT;
        ST_WB:    state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: cleared on entry to the loop, advanced only when TEST
  // loops back to SHIFT, so it naturally stops at ITERS-1 and holds there
  // until the next LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
    end else if (cancel && state != ST_IDLE) begin
      iter <= '0;
    end else if (state == ST_LOAD) begin
      iter <= '0;
    end else if (state == ST_TEST && !last_iter) begin
      iter <= iter + CNT_W'(1);
    end
  end

  sqrt_seq_decode u_decode (
    .state  (state),
    .au_neg (au_neg),
    .ctrl   (ctrl)
  );

  assign busy         = ctrl.busy;
  assign done         = ctrl.done;
  assign rad_ld       = ctrl.rad_ld;
  assign rem_clr      = ctrl.rem_clr;
  assign root_clr     = ctrl.root_clr;
  assign sh_en        = ctrl.sh_en;
  assign au_op        = ctrl.au_op;
  assign au_tri       = ctrl.au_tri;
  assign in_tri       = ctrl.in_tri;
  assign rem_ld       = ctrl.rem_ld;
  assign root_lsb_set = ctrl.root_lsb_set;
  assign rf_oe        = ctrl.rf_oe;
  assign rf_ws        = ctrl.rf_ws;
  assign rf_rs        = ctrl.rf_rs;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_seq_ctrl
// Directed bench for sqrt_seq_ctrl. Two instances share clock and reset: one
// at DATA_W=8 (4 iterations) and one at DATA_W=12 (6 iterations). Cycle 1 is
// the first cycle after the edge that samples start; expected outputs come
// from the cycle timetable (LOAD 1, SHIFT/SUB/TEST at 2+3k/3+3k/4+3k, WB at
// 2+3*ITERS, DONE at 3+3*ITERS). Abort scenarios compile in only when
// SQRT_SEQ_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sqrt_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start8, start12;
  logic au_neg;
  logic abort;

  logic       busy8, done8, rad_ld8, rem_clr8, root_clr8, sh_en8, au_tri8, in_tri8;
  logic       rem_ld8, root_lsb_set8, rf_oe8, rf_ws8, rf_rs8;
  logic [1:0] au_op8;
  logic [1:0] iter8;

  logic       busy12, done12, rad_ld12, rem_clr12, root_clr12, sh_en12, au_tri12, in_tri12;
  logic       rem_ld12, root_lsb_set12, rf_oe12, rf_ws12, rf_rs12;
  logic [1:0] au_op12;
  logic [2:0] iter12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sqrt_seq_ctrl #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .au_neg(au_neg),
`ifdef SQRT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy8), .done(done8), .iter(iter8), .rad_ld(rad_ld8), .rem_clr(rem_clr8),
    .root_clr(root_clr8), .sh_en(sh_en8), .au_op(au_op8), .au_tri(au_tri8),
    .in_tri(in_tri8), .rem_ld(rem_ld8), .root_lsb_set(root_lsb_set8),
    .rf_oe(rf_oe8), .rf_ws(rf_ws8), .rf_rs(rf_rs8)
  );

  sqrt_seq_ctrl #(.DATA_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .au_neg(au_neg),
`ifdef SQRT_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy12), .done(done12), .iter(iter12), .rad_ld(rad_ld12), .rem_clr(rem_clr12),
    .root_clr(root_clr12), .sh_en(sh_en12), .au_op(au_op12), .au_tri(au_tri12),
    .in_tri(in_tri12), .rem_ld(rem_ld12), .root_lsb_set(root_lsb_set12),
    .rf_oe(rf_oe12), .rf_ws(rf_ws12), .rf_rs(rf_rs12)
  );

  // Output words: {busy, done, rad_ld, rem_clr, root_clr, sh_en, au_op,
  // au_tri, in_tri, rem_ld, root_lsb_set, rf_oe, rf_ws, rf_rs}
  wire [14:0] vec8  = {busy8, done8, rad_ld8, rem_clr8, root_clr8, sh_en8, au_op8,
                       au_tri8, in_tri8, rem_ld8, root_lsb_set8, rf_oe8, rf_ws8, rf_rs8};
  wire [14:0] vec12 = {busy12, done12, rad_ld12, rem_clr12, root_clr12, sh_en12, au_op12,
                       au_tri12, in_tri12, rem_ld12, root_lsb_set12, rf_oe12, rf_ws12, rf_rs12};

  // Expected output word for timetable cycle c of a run with the given
  // iteration count; neg is the au_neg value driven in that cycle.
  function automatic logic [14:0] exp_vec(input int c, input logic neg, input int iters);
    logic [14:0] v;
    v = '0;
    if (c == 1) begin
      v = 15'b1_0_1_1_1_0_00_0_1_0_0_0_0_0;
    end else if (c >= 2 && c <= 1 + 3 * iters) begin
      case ((c - 2) % 3)
        0:       v = 15'b1_0_0_0_0_1_11_0_0_0_0_0_0_0;
        1:       v = 15'b1_0_0_0_0_0_10_1_0_0_0_0_0_0;
        default: v = {1'b1, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b0, ~neg, ~neg, 3'b000};
      endcase
    end else if (c == 2 + 3 * iters) begin
      v = 15'b1_0_0_0_0_0_00_0_0_0_0_1_1_0;
    end else if (c == 3 + 3 * iters) begin
      v = 15'b1_1_0_0_0_0_00_0_0_0_0_0_0_0;
    end
    return v;
  endfunction

  // Expected iteration index, or -1 where it is not pinned (LOAD, pre-run).
  function automatic int exp_iter(input int c, input int iters);
    if (c >= 2 && c <= 1 + 3 * iters) return (c - 2) / 3;
    if (c > 1 + 3 * iters)            return iters - 1;
    return -1;
  endfunction

  task automatic step_to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start8  = 1'b0;
    start12 = 1'b0;
    au_neg  = 1'b0;
    abort   = 1'b0;
    #3;
    n_checks++;
    if (vec8 !== 15'd0 || iter8 !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset8: outputs=%b iter=%0d, required all 0", vec8, iter8);
    end
    n_checks++;
    if (vec12 !== 15'd0 || iter12 !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL reset12: outputs=%b iter=%0d, required all 0", vec12, iter12);
    end
    #20;
    rst_n = 1'b1;
    step_to_drive();
    #1;
    n_checks++;
    if (vec8 !== 15'd0 || iter8 !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: outputs=%b iter=%0d, required all 0", vec8, iter8);
    end
  endtask

  // One operation from a start pulse. neg_pat[k] is driven on au_neg during
  // iteration k. Every cycle is compared against the timetable, and exactly
  // one done pulse is required in the DONE cycle.
  task automatic run_op(input bit wide, input logic [5:0] neg_pat, input string name);
    int          iters;
    int          n_done;
    int          ei;
    logic [14:0] got;
    int          got_iter;
    iters  = wide ? 6 : 4;
    n_done = 0;
    if (wide) start12 = 1'b1; else start8 = 1'b1;
    for (int c = 1; c <= 4 + 3 * iters; c++) begin
      step_to_drive();
      start8  = 1'b0;
      start12 = 1'b0;
      au_neg  = (c >= 2 && c <= 1 + 3 * iters) ? neg_pat[(c - 2) / 3] : 1'b0;
      #1;
      got      = wide ? vec12 : vec8;
      got_iter = wide ? int'(iter12) : int'(iter8);
      if (got[13]) n_done++;
      n_checks++;
      if (got !== exp_vec(c, au_neg, iters)) begin
        n_fail++;
        $display("[TB] FAIL %s outputs cycle %0d: got %b, required %b",
                 name, c, got, exp_vec(c, au_neg, iters));
      end
      ei = exp_iter(c, iters);
      if (ei >= 0) begin
        n_checks++;
        if (got_iter != ei) begin
          n_fail++;
          $display("[TB] FAIL %s iter cycle %0d: got %0d, required %0d", name, c, got_iter, ei);
        end
      end
    end
    au_neg = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("[TB] FAIL %s done_count: got %0d, required 1", name, n_done);
    end
  endtask

  task automatic test_reset_mid_run();
    start8 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step_to_drive();
      start8 = 1'b0;
    end
    #1;
    n_checks++;
    if (vec8 !== exp_vec(7, 1'b0, 4) || iter8 !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset cycle 7: got %b iter=%0d, required %b iter=1",
               vec8, iter8, exp_vec(7, 1'b0, 4));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vec8 !== 15'd0 || iter8 !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run immediate: outputs=%b iter=%0d, required all 0", vec8, iter8);
    end
    step_to_drive();
    step_to_drive();
    rst_n = 1'b1;
    step_to_drive();
    #1;
    n_checks++;
    if (vec8 !== 15'd0 || iter8 !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run release: outputs=%b iter=%0d, required all 0", vec8, iter8);
    end
  endtask

  // start held from cycle 3 through the IDLE cycle after DONE: the busy-time
  // requests are dropped, and the IDLE cycle (16) launches LOAD at 17. The
  // second run then follows the timetable shifted by 16 cycles.
  task automatic test_back_to_back();
    int n_done;
    int cc;
    n_done = 0;
    start8 = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step_to_drive();
      start8 = (c >= 3 && c <= 16) ? 1'b1 : 1'b0;
      #1;
      cc = (c <= 16) ? c : c - 16;
      if (done8) n_done++;
      n_checks++;
      if (vec8 !== exp_vec(cc, 1'b0, 4)) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b, required %b",
                 c, vec8, exp_vec(cc, 1'b0, 4));
      end
      if (c == 16) begin
        n_checks++;
        if (n_done != 1) begin
          n_fail++;
          $display("[TB] FAIL back_to_back first_done_count: got %0d, required 1", n_done);
        end
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (n_done != 2) begin
      n_fail++;
      $display("[TB] FAIL back_to_back total_done_count: got %0d, required 2", n_done);
    end
  endtask

`ifdef SQRT_SEQ_ABORT_EN
  task automatic test_abort();
    int n_done;
    n_done = 0;
    start8 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step_to_drive();
      start8 = 1'b0;
      abort  = (c == 6) ? 1'b1 : 1'b0;
      #1;
      if (done8) n_done++;
      if (c == 6) begin
        n_checks++;
        if (busy8 !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL abort cycle 6 busy: got %b, required 1", busy8);
        end
      end
      if (c >= 7) begin
        n_checks++;
        if (vec8 !== 15'd0 || iter8 !== 2'd0) begin
          n_fail++;
          $display("[TB] FAIL abort idle cycle %0d: outputs=%b iter=%0d, required all 0",
                   c, vec8, iter8);
        end
      end
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("[TB] FAIL abort done_count: got %0d, required 0", n_done);
    end
    start8 = 1'b1;
    abort  = 1'b1;
    step_to_drive();
    start8 = 1'b0;
    abort  = 1'b0;
    #1;
    n_checks++;
    if (vec8 !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_with_start: outputs=%b, required all 0", vec8);
    end
  endtask
`endif

  initial begin
    test_reset();
    run_op(1'b0, 6'b000000, "neg0_w8");
    run_op(1'b0, 6'b001111, "neg1_w8");
    run_op(1'b0, 6'b000101, "negmix_w8");
    test_reset_mid_run();
    test_back_to_back();
    run_op(1'b1, 6'b100110, "w12");
`ifdef SQRT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Parametrised, self-sequencing controller for the structural integer square-root datapath. It owns the state register, an iteration counter and a start/busy/done handshake, and Moore-decodes state into register-enable, AU-op, tri-state and register-file strobes. It generalises the fixed 4-bit-state control decoder to any even radicand width. The decision path uses the AU sign flag. It sits between the top-level sequencer (start/done) and the SQR_STRUC datapath.

## Interface
- DATA_W, 8, radicand width in bits; even, ≥4.
- ITERS, DATA_W/2, derived: number of root-bit iterations.
- CNT_W, $clog2(ITERS), derived: iteration-counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- au_neg  in  1  sign of AU1 trial subtraction; sampled in TEST.
- abort  in  1  cancel request; present only with SQRT_SEQ_ABORT_EN.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- iter  out  CNT_W  current iteration index, 0..ITERS-1.
- rad_ld, rem_clr, root_clr  out  1  each, high in LOAD.
- sh_en  out  1  high in SHIFT.
- au_op  out  2  AU1 opcode: PASS=00 by default, SHL=11 in SHIFT, SUB=10 in SUB.
- au_tri  out  1  AU1 bus driver, high in SUB and TEST.
- in_tri  out  1  input-bus driver, high in LOAD.
- rem_ld  out  1  high in TEST when au_neg=0.
- root_lsb_set  out  1  high in TEST when au_neg=0.
- rf_oe, rf_ws  out  1  each, high in WB.
- rf_rs  out  1  constant 0.

## Operation
- States: IDLE, LOAD, SHIFT, SUB, TEST, WB, DONE.
- IDLE→LOAD on start; otherwise hold.
- LOAD→SHIFT; iter←0.
- SHIFT→SUB→TEST.
- TEST→SHIFT with iter+1 when iter<ITERS-1; otherwise TEST→WB.
- WB→DONE→IDLE unconditionally.
- Outputs are pure combinational decodes of the registered state, iter and au_neg. In IDLE every output is 0.
- start while busy is ignored, with no queuing.
- iter never wraps: it saturates at ITERS-1 and is cleared only in LOAD or by reset.
- Reset at any time forces IDLE and iter=0 immediately. All outputs are 0 while rst_n=0.

## Timing
- start sampled high at edge 0 (IDLE) gives LOAD in cycle 1.
- Iteration k occupies cycles: SHIFT at 2+3k, SUB at 3+3k, TEST at 4+3k.
- WB in cycle 2+3·ITERS; DONE in cycle 3+3·ITERS.
- For DATA_W=8: done is high in cycle 15 only; busy is high in cycles 1–15.
- Back-to-back operation: start held high through DONE begins the next LOAD 2 cycles after DONE (the IDLE cycle samples it).
- au_neg must be stable during TEST. rem_ld and root_lsb_set follow it combinationally in that cycle.

## Configuration
- SQRT_SEQ_ABORT_EN defined:
  - abort port exists.
  - abort high in any busy state forces IDLE at the next edge and iter←0; done does not pulse.
  - abort in IDLE with start: abort wins and the FSM stays IDLE.
- SQRT_SEQ_ABORT_EN undefined: no abort port; an operation always runs to DONE.

## Structure
- Package sqrt_seq_pkg holds:
  - the state enum (3-bit encoding, IDLE=0);
  - AU op constants AU_PASS, AU_ADD=01, AU_SUB, AU_SHL;
  - a control-bundle struct.
- Sub-module sqrt_seq_decode: combinational state/au_neg → control bundle. The top holds the state register, counter and handshake.

## Test plan
- Reset mid-run (rst_n low in cycle 7, DATA_W=8) → all outputs 0 immediately; IDLE, iter=0 after release.
- start pulse, au_neg tied 0, DATA_W=8 → root_lsb_set and rem_ld high in cycles 4, 7, 10, 13; rf_ws in 14; done in 15 only.
- start pulse, au_neg tied 1 → rem_ld and root_lsb_set never high; done still in cycle 15.
- start re-asserted in cycles 3–12 → ignored; exactly one done; start held through DONE begins the next LOAD 2 cycles after DONE.
- DATA_W=12 (ITERS=6) → iter steps 0..5; done in cycle 21.
- With SQRT_SEQ_ABORT_EN: abort in cycle 6 → IDLE in cycle 7, busy=0, no done pulse; start+abort in IDLE → stays IDLE.
